bitwise_logic_unit: RTL and testbench

BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

---
 rtl/blu_pkg.sv | 27 ++
 rtl/blu_chunk_alu.sv | 39 +++
 rtl/bitwise_logic_unit.sv | 131 +++++++++++++
 tb/tb_bitwise_logic_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blu_pkg.sv
// blu_pkg: shared op-code and FSM state types plus default sizing
// for the chunked bitwise logic unit.
package blu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [2:0] {
    OP_OR   = 3'b000,
    OP_AND  = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_ORN  = 3'b100,
    OP_CPOP = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op < 3'b110;
  endfunction

endpackage

// File: rtl/blu_chunk_alu.sv
// blu_chunk_alu: one CHUNK-wide slice of the logic op (op_i, a_i, b_i)
// -> res_o, plus pop_o = popcount(a_i | b_i) for CPOP accumulation.
module blu_chunk_alu
  import blu_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK,
  localparam int PW = $clog2(CHUNK + 1)
) (
  input  logic [2:0]       op_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic [CHUNK-1:0] res_o,
  output logic [PW-1:0]    pop_o
);

  logic [CHUNK-1:0] ab_or;

  assign ab_or = a_i | b_i;

  always_comb begin
    res_o = '0;
    unique case (1'b1)
      op_i == OP_OR:  res_o = ab_or;
      op_i == OP_AND: res_o = a_i & b_i;
      op_i == OP_XOR: res_o = a_i ^ b_i;
      op_i == OP_NOR: res_o = ~ab_or;
      op_i == OP_ORN: res_o = a_i | ~b_i;
      default:        res_o = '0;
    endcase
  end

  always_comb begin
    pop_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pop_o = pop_o + PW'(ab_or[i]);
    end
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: chunk-serial logic unit; a_i/b_i/op_i in on valid_i/ready_o,
// s_o/zero_o/err_o out on valid_o/ready_i, WIDTH/CHUNK cycles per op.
module bitwise_logic_unit
  import blu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] s_o,
  output logic             zero_o,
  output logic             err_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(CHUNK + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("bitwise_logic_unit: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q;
  state_e           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    acc_q;
  logic [IW-1:0]    off;
  logic [CHUNK-1:0] alu_res;
  logic [PW-1:0]    alu_pop;
  logic [WIDTH-1:0] fin_s;
  logic             accept;
  logic             last;
  logic             deliver;

  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i && ready_o;
  assign last    = (cnt_q == CW'(N - 1));
  assign deliver = valid_o && ready_i;
  assign off     = IW'(cnt_q) * IW'(CHUNK);

  blu_chunk_alu #(
    .CHUNK (CHUNK)
  ) u_alu (
    .op_i  (op_q),
    .a_i   (a_q[off +: CHUNK]),
    .b_i   (b_q[off +: CHUNK]),
    .res_o (alu_res),
    .pop_o (alu_pop)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_i) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (deliver) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fin_s = res_q;
    if (op_q == OP_CPOP) begin
      fin_s = WIDTH'(acc_q);
    end else if (!op_legal(op_q)) begin
      fin_s = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // First DONE cycle latches the assembled result onto the outputs;
  // outputs otherwise hold so a stalled consumer sees stable data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      s_o     <= '0;
      zero_o  <= 1'b1;
      err_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a_i;
        b_q   <= b_i;
        op_q  <= op_i;
        cnt_q <= '0;
        acc_q <= '0;
      end
      if (state_q == BUSY) begin
        res_q[off +: CHUNK] <= alu_res;
        acc_q <= acc_q + AW'(alu_pop);
        cnt_q <= last ? '0 : cnt_q + CW'(1);
      end
      if (state_q == DONE && !valid_o) begin
        s_o     <= fin_s;
        zero_o  <= (fin_s == '0);
        err_o   <= !op_legal(op_q);
        valid_o <= 1'b1;
      end
      if (deliver) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb_bitwise_logic_unit: directed vectors into a scoreboard queue,
// negedge monitors compare results, latency and stall stability.
module tb_bitwise_logic_unit;

  typedef struct {
    logic [31:0] s;
    logic        z;
    logic        e;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] a0 = '0, b0 = '0, s0;
  logic [2:0]  op0 = '0;
  logic        v0 = 1'b0, ro0, z0, e0, vo0, rdy0 = 1'b1;
  logic [31:0] a1 = '0, b1 = '0, s1;
  logic [2:0]  op1 = '0;
  logic        v1 = 1'b0, ro1, z1, e1, vo1, rdy1 = 1'b1;

  exp_t q0[$];
  exp_t q1[$];
  bit   busy0 = 0;
  bit   up0 = 0, up1 = 0;
  logic [31:0] hs0, hs1;
  logic hz0, he0, hz1, he1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitwise_logic_unit u_dut0 (
    .clk_i (clk), .rst_i (rst),
    .a_i (a0), .b_i (b0), .op_i (op0),
    .valid_i (v0), .ready_o (ro0),
    .s_o (s0), .zero_o (z0), .err_o (e0),
    .valid_o (vo0), .ready_i (rdy0)
  );

  bitwise_logic_unit #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk_i (clk), .rst_i (rst),
    .a_i (a1), .b_i (b1), .op_i (op1),
    .valid_i (v1), .ready_o (ro1),
    .s_o (s1), .zero_o (z1), .err_o (e1),
    .valid_o (vo1), .ready_i (rdy1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected none", name);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      up0 = 0;
    end else begin
      if (busy0) chk("ready_busy0", 32'(ro0), 32'd0);
      if (vo0) begin
        if (q0.size() == 0) begin
          bad("unexpected_valid0");
        end else begin
          if (!up0) begin
            chk("latency0", cyc, q0[0].lat);
            up0 = 1; hs0 = s0; hz0 = z0; he0 = e0;
          end else begin
            chk("stable_s0", s0, hs0);
            chk("stable_z0", 32'(z0), 32'(hz0));
            chk("stable_e0", 32'(e0), 32'(he0));
          end
          if (rdy0) begin
            chk("s0", s0, q0[0].s);
            chk("zero0", 32'(z0), 32'(q0[0].z));
            chk("err0", 32'(e0), 32'(q0[0].e));
            void'(q0.pop_front());
            up0 = 0;
            busy0 = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      up1 = 0;
    end else if (vo1) begin
      if (q1.size() == 0) begin
        bad("unexpected_valid1");
      end else begin
        if (!up1) begin
          chk("latency1", cyc, q1[0].lat);
          up1 = 1; hs1 = s1; hz1 = z1; he1 = e1;
        end else begin
          chk("stable_s1", s1, hs1);
        end
        if (rdy1) begin
          chk("s1", s1, q1[0].s);
          chk("zero1", 32'(z1), 32'(q1[0].z));
          chk("err1", 32'(e1), 32'(q1[0].e));
          void'(q1.pop_front());
          up1 = 0;
        end
      end
    end
  end

  task automatic issue(input int inst, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] s, input logic z,
                       input logic e, input bit push);
    exp_t x;
    int   n;
    @(negedge clk);
    if (inst == 0) begin
      a0 = a; b0 = b; op0 = op; v0 = 1'b1;
    end else begin
      a1 = a; b1 = b; op1 = op; v1 = 1'b1;
    end
    n = 0;
    while (((inst == 0) ? ro0 : ro1) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bad("accept_timeout");
    x.s = s; x.z = z; x.e = e;
    x.lat = cyc + 1 + ((inst == 0) ? 4 : 1) + 1;
    if (push) begin
      if (inst == 0) q0.push_back(x);
      else q1.push_back(x);
    end
    @(posedge clk);
    #1;
    if (inst == 0) begin
      v0 = 1'b0; a0 = ~a; b0 = ~b; busy0 = 1;
    end else begin
      v1 = 1'b0; a1 = ~a; b1 = ~b;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) bad("drain_timeout");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", 32'(ro0), 32'd1);
    chk("rst_valid0", 32'(vo0), 32'd0);
    chk("rst_s0", s0, 32'd0);
    chk("rst_zero0", 32'(z0), 32'd1);
    chk("rst_err0", 32'(e0), 32'd0);
    chk("rst_ready1", 32'(ro1), 32'd1);
    chk("rst_valid1", 32'(vo1), 32'd0);
    chk("rst_zero1", 32'(z1), 32'd1);
    rst = 1'b0;

    issue(0, 32'h12345678, 32'hFEDCBA98, 3'b000, 32'hFEFCFEF8, 0, 0, 1);
    issue(0, 32'h12345678, 32'hFEDCBA98, 3'b001, 32'h12141218, 0, 0, 1);
    issue(0, 32'h12345678, 32'hFEDCBA98, 3'b010, 32'hECE8ECE0, 0, 0, 1);
    issue(0, 32'hFFFF0000, 32'h00000000, 3'b101, 32'h00000010, 0, 0, 1);
    issue(0, 32'h00000000, 32'h00000000, 3'b011, 32'hFFFFFFFF, 0, 0, 1);
    issue(0, 32'h00000000, 32'h00000000, 3'b000, 32'h00000000, 1, 0, 1);
    issue(0, 32'h0F0F0000, 32'h00FF00FF, 3'b100, 32'hFF0FFF00, 0, 0, 1);
    issue(0, 32'h12345678, 32'hFEDCBA98, 3'b101, 32'h00000019, 0, 0, 1);
    issue(0, 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b010, 32'h00000000, 1, 0, 1);
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h00000000, 1, 1, 1);
    drain();

    rdy0 = 1'b0;
    issue(0, 32'hDEADBEEF, 32'h01234567, 3'b111, 32'h00000000, 1, 1, 1);
    n = 0;
    while (!vo0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid0", 32'(vo0), 32'd1);
    end
    @(posedge clk);
    #1 rdy0 = 1'b1;
    drain();

    issue(1, 32'h12345678, 32'hFEDCBA98, 3'b000, 32'hFEFCFEF8, 0, 0, 1);
    issue(1, 32'h12345678, 32'hFEDCBA98, 3'b101, 32'h00000019, 0, 0, 1);
    issue(1, 32'h00000001, 32'h00000002, 3'b111, 32'h00000000, 1, 1, 1);
    drain();

    issue(0, 32'h12345678, 32'hFEDCBA98, 3'b000, 32'hFEFCFEF8, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    v0 = 1'b1;
    busy0 = 0;
    @(posedge clk);
    #1;
    chk("busy_rst_ready0", 32'(ro0), 32'd1);
    chk("busy_rst_valid0", 32'(vo0), 32'd0);
    chk("busy_rst_s0", s0, 32'd0);
    chk("busy_rst_zero0", 32'(z0), 32'd1);
    rst = 1'b0;
    v0 = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid_ignored0", 32'(ro0), 32'd1);
    repeat (8) @(negedge clk);

    issue(0, 32'h0000F000, 32'h000000F0, 3'b000, 32'h0000F0F0, 0, 0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
